char_mem_ctrl: RTL and testbench
================================

Name: char_mem_ctrl

Overview:
- Controller and arbiter in front of a 4-column x 5-row, 1-bit character glyph memory.
- Accepts whole 20-bit glyphs from a host over a valid/ready handshake. Serializes each glyph into 20 single-bit memory writes.
- Shares the memory's single x/y address port with a display pixel reader. The reader has priority; a starvation limit guarantees the loader progresses.

Parameters:
- STARVE_LIMIT, 8: consecutive loader-stalled cycles after which the loader takes one forced write slot.

Ports:
- clock  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- load_valid  in  1  host glyph offered
- load_ready  out  1  controller can accept a glyph
- load_data  in  20  glyph; bit r*4+c = row r, column c
- load_done  out  1  one-cycle pulse when a glyph is fully written
- rd_req  in  1  display pixel read request
- rd_ready  out  1  read accepted this cycle (combinational)
- rd_x  in  2  read column
- rd_y  in  3  read row
- rd_valid  out  1  registered; rd_pixel valid
- rd_pixel  out  1  registered read result
- mem_write  out  1  memory write strobe (combinational)
- mem_x  out  2  memory column address (combinational)
- mem_y  out  3  memory row address (combinational)
- mem_data_in  out  1  memory write data
- mem_data_out  in  1  memory combinational read data
- busy  out  1  state != IDLE

Behaviour:
- Reset is rst_n, synchronous, active-low, on clock. While rst_n=0: load_ready=0, rd_ready=0, mem_write=0.
- On the first cycle after reset: state=IDLE, row=col=0, stall_cnt=0, rd_valid=0, rd_pixel=0, load_done=0, busy=0.
- Reset asserted mid-load aborts the load. The remaining bits are not written; the memory's own reset restores its default contents.
- FSM states: IDLE, LOAD, DONE.
  - IDLE: load_ready=1. A transfer fires when load_valid=1 and load_ready=1. On transfer, load_data is captured into a shadow register, row=col=0, stall_cnt=0, next state LOAD.
  - LOAD: load_ready=0, busy=1.
  - DONE: single cycle; load_done=1, load_ready=0, busy=1; next state IDLE.
- Loader slot, LOAD state only. The loader owns the memory port in a cycle when rd_req=0, or when stall_cnt==STARVE_LIMIT. In a loader-owned cycle:
  - mem_write=1, mem_x=col, mem_y=row, mem_data_in=shadow[row*4+col];
  - stall_cnt resets to 0;
  - col increments; at col=3 it wraps to 0 and row increments;
  - the write at row=4, col=3 moves the FSM to DONE.
- In LOAD, when rd_req=1 and stall_cnt<STARVE_LIMIT: mem_write=0, row/col hold, stall_cnt increments.
- Read grant:
  - rd_ready=1 when rst_n=1 and not (state==LOAD and stall_cnt==STARVE_LIMIT).
  - On rd_req and rd_ready: mem_x=rd_x, mem_y=rd_y, mem_write=0.
  - Next cycle: rd_valid=1 and rd_pixel=mem_data_out; if rd_y>4, rd_pixel=0.
  - Otherwise rd_valid=0 next cycle, and rd_pixel holds its last value.
  - Read latency is 1 cycle. A refused requester holds rd_req, rd_x and rd_y.
- Idle port: with no grant, mem_x=0, mem_y=0, mem_data_in=0.
- Load timing with no reads: transfer at cycle N; writes at N+1..N+20; load_done=1 at N+21; load_ready=1 at N+22.
- Back-to-back: load_valid held high starts the next glyph at N+22. load_valid is ignored outside IDLE.
- Read/write conflict: a read in the same cycle as a would-be write always wins unless the starvation slot is due. A read of a bit not yet rewritten returns old content; no forwarding from the shadow register.

Test Plan:
- Reset, then load_data=20'hF0F0F with no reads -> 20 writes in cycles N+1..N+20 at (x,y)=(0,0),(1,0)..(3,4); data pattern 1,1,1,1,0,0,0,0,...; load_done at N+21; read-back of all 20 cells matches.
- Load 20'h00001 while rd_req held continuously with rd_x=2, rd_y=1 -> rd_valid every cycle except one forced loader slot after each 8 stalled cycles (rd_ready=0 there); load completes in 20*9 = 180 LOAD cycles; load_done pulses once.
- Single read rd_x=3, rd_y=4 after loading 20'h80000 -> rd_valid=1, rd_pixel=1 one cycle later; rd_y=5 -> rd_valid=1, rd_pixel=0.
- rst_n dropped after 7 writes -> mem_write=0 immediately; after release state=IDLE, load_ready=1, no load_done pulse, busy=0.
- load_valid held high with two successive glyphs A=20'h12345, B=20'hABCDE -> B accepted at N+22; final memory contents equal B; exactly two load_done pulses.
- load_valid pulsed during LOAD/DONE -> ignored; load_ready stays 0; no second capture.

Source files
------------

// File: rtl/char_mem_ctrl_if.sv
// rtl/char_mem_ctrl_if.sv - host load, display read and glyph memory port bundle for char_mem_ctrl
interface char_mem_ctrl_if;
  logic        load_valid;
  logic        load_ready;
  logic [19:0] load_data;
  logic        load_done;
  logic        rd_req;
  logic        rd_ready;
  logic [1:0]  rd_x;
  logic [2:0]  rd_y;
  logic        rd_valid;
  logic        rd_pixel;
  logic        mem_write;
  logic [1:0]  mem_x;
  logic [2:0]  mem_y;
  logic        mem_data_in;
  logic        mem_data_out;
  logic        busy;

  modport master (
    output load_valid, load_data, rd_req, rd_x, rd_y, mem_data_out,
    input  load_ready, load_done, rd_ready, rd_valid, rd_pixel,
           mem_write, mem_x, mem_y, mem_data_in, busy
  );

  modport slave (
    input  load_valid, load_data, rd_req, rd_x, rd_y, mem_data_out,
    output load_ready, load_done, rd_ready, rd_valid, rd_pixel,
           mem_write, mem_x, mem_y, mem_data_in, busy
  );
endinterface

// File: rtl/char_mem_ctrl.sv
// rtl/char_mem_ctrl.sv - glyph loader serializer and read-priority arbiter for a 4x5 bit glyph memory
module char_mem_ctrl #(
  parameter int STARVE_LIMIT = 8
) (
  input  logic            clock,
  input  logic            rst_n,
  char_mem_ctrl_if.slave  bus
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STALL_MAX = SW'(STARVE_LIMIT);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    r_state;
  logic [19:0]   r_shadow;
  logic [2:0]    r_row;
  logic [1:0]    r_col;
  logic [SW-1:0] r_stall;
  logic          r_rd_valid;
  logic          r_rd_pixel;

  logic          w_starve;
  logic          w_rd_ready;
  logic          w_rd_grant;
  logic          w_ld_slot;
  logic          w_load_ready;
  logic          w_xfer;
  logic          w_last_bit;
  logic [4:0]    w_bit_idx;

  // The starvation slot steals the port from the reader for exactly one cycle.
  assign w_starve     = (r_state == S_LOAD) && (r_stall == STALL_MAX);
  assign w_rd_ready   = rst_n && !w_starve;
  assign w_rd_grant   = bus.rd_req && w_rd_ready;
  assign w_ld_slot    = rst_n && (r_state == S_LOAD) && (!bus.rd_req || w_starve);
  assign w_load_ready = rst_n && (r_state == S_IDLE);
  assign w_xfer       = bus.load_valid && w_load_ready;
  assign w_bit_idx    = {r_row, r_col};
  assign w_last_bit   = (r_row == 3'd4) && (r_col == 2'd3);

  assign bus.load_ready = w_load_ready;
  assign bus.rd_ready   = w_rd_ready;
  assign bus.load_done  = (r_state == S_DONE);
  assign bus.busy       = (r_state != S_IDLE);
  assign bus.rd_valid   = r_rd_valid;
  assign bus.rd_pixel   = r_rd_pixel;

  always_comb begin
    bus.mem_write   = 1'b0;
    bus.mem_x       = 2'd0;
    bus.mem_y       = 3'd0;
    bus.mem_data_in = 1'b0;
    if (w_ld_slot) begin
      bus.mem_write   = 1'b1;
      bus.mem_x       = r_col;
      bus.mem_y       = r_row;
      bus.mem_data_in = r_shadow[w_bit_idx];
    end else if (w_rd_grant) begin
      bus.mem_x = bus.rd_x;
      bus.mem_y = bus.rd_y;
    end
  end

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_shadow   <= 20'd0;
      r_row      <= 3'd0;
      r_col      <= 2'd0;
      r_stall    <= '0;
      r_rd_valid <= 1'b0;
      r_rd_pixel <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_grant;
      // Rows past the glyph read as blank regardless of what the memory returns.
      if (w_rd_grant) begin
        r_rd_pixel <= (bus.rd_y > 3'd4) ? 1'b0 : bus.mem_data_out;
      end

      case (r_state)
        S_IDLE: begin
          if (w_xfer) begin
            r_shadow <= bus.load_data;
            r_row    <= 3'd0;
            r_col    <= 2'd0;
            r_stall  <= '0;
            r_state  <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (w_ld_slot) begin
            r_stall <= '0;
            if (w_last_bit) begin
              r_state <= S_DONE;
            end else if (r_col == 2'd3) begin
              r_col <= 2'd0;
              r_row <= r_row + 3'd1;
            end else begin
              r_col <= r_col + 2'd1;
            end
          end else begin
            r_stall <= r_stall + SW'(1);
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_char_mem_ctrl.sv
// tb/tb_char_mem_ctrl.sv - self-checking bench for char_mem_ctrl with glyph memory model
module tb_char_mem_ctrl;
  localparam int LIMIT = 8;

  logic clock = 1'b0;
  logic rst_n = 1'b0;
  always #5 clock = ~clock;

  char_mem_ctrl_if bus ();

  char_mem_ctrl #(.STARVE_LIMIT(LIMIT)) dut (
    .clock (clock),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Glyph memory: out-of-glyph addresses read back 1 so the blanking of rows > 4 is visible.
  logic [19:0] dev_mem;
  int          dev_idx;
  logic        dev_rdata;
  always_comb begin
    dev_idx   = int'(bus.mem_y) * 4 + int'(bus.mem_x);
    dev_rdata = (dev_idx < 20) ? dev_mem[dev_idx] : 1'b1;
  end
  assign bus.mem_data_out = dev_rdata;
  always @(posedge clock) begin
    if (!rst_n) dev_mem <= '0;
    else if (bus.mem_write && dev_idx < 20) dev_mem[dev_idx] <= bus.mem_data_in;
  end

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Reference model: phase 0 idle, 1 loading bit m_k, 2 done.
  int          m_phase = 0;
  int          m_k = 0;
  int          m_stall = 0;
  logic [19:0] m_glyph = '0;
  logic [19:0] exp_mem = '0;
  logic        m_rdv = 1'b0;
  logic        m_rdp = 1'b0;

  logic obs_load_ready, obs_load_done, obs_rd_ready, obs_rd_valid, obs_rd_pixel;
  logic obs_mem_write, obs_din, obs_busy;
  logic [1:0] obs_mem_x;
  logic [2:0] obs_mem_y;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      if (n_errors <= 40)
        $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    bit starve, slot, grant;
    logic [1:0] ex;
    logic [2:0] ey;
    logic ed;
    @(negedge clock);
    cyc++;
    obs_load_ready = bus.load_ready;
    obs_load_done  = bus.load_done;
    obs_rd_ready   = bus.rd_ready;
    obs_rd_valid   = bus.rd_valid;
    obs_rd_pixel   = bus.rd_pixel;
    obs_mem_write  = bus.mem_write;
    obs_mem_x      = bus.mem_x;
    obs_mem_y      = bus.mem_y;
    obs_din        = bus.mem_data_in;
    obs_busy       = bus.busy;
    starve = (m_phase == 1) && (m_stall == LIMIT);
    slot   = (m_phase == 1) && (!bus.rd_req || starve);
    grant  = bus.rd_req && !starve;
    if (!rst_n) begin
      chk("rst_load_ready", 32'(obs_load_ready), 32'd0);
      chk("rst_rd_ready", 32'(obs_rd_ready), 32'd0);
      chk("rst_mem_write", 32'(obs_mem_write), 32'd0);
    end else begin
      ex = slot ? 2'(m_k % 4) : grant ? bus.rd_x : 2'd0;
      ey = slot ? 3'(m_k / 4) : grant ? bus.rd_y : 3'd0;
      ed = slot ? m_glyph[m_k] : 1'b0;
      chk("rd_ready", 32'(obs_rd_ready), 32'(!starve));
      chk("mem_write", 32'(obs_mem_write), 32'(slot));
      chk("mem_x", 32'(obs_mem_x), 32'(ex));
      chk("mem_y", 32'(obs_mem_y), 32'(ey));
      chk("mem_data_in", 32'(obs_din), 32'(ed));
      chk("load_ready", 32'(obs_load_ready), 32'(m_phase == 0));
      chk("load_done", 32'(obs_load_done), 32'(m_phase == 2));
      chk("busy", 32'(obs_busy), 32'(m_phase != 0));
      chk("rd_valid", 32'(obs_rd_valid), 32'(m_rdv));
      chk("rd_pixel", 32'(obs_rd_pixel), 32'(m_rdp));
    end
    @(posedge clock);
    if (!rst_n) begin
      m_phase = 0; m_k = 0; m_stall = 0; m_rdv = 1'b0; m_rdp = 1'b0; exp_mem = '0;
    end else begin
      m_rdv = grant;
      if (grant) m_rdp = (bus.rd_y > 3'd4) ? 1'b0 : exp_mem[int'(bus.rd_y) * 4 + int'(bus.rd_x)];
      case (m_phase)
        0: if (bus.load_valid) begin
             m_glyph = bus.load_data; m_k = 0; m_stall = 0; m_phase = 1;
           end
        1: if (slot) begin
             exp_mem[m_k] = m_glyph[m_k];
             m_stall = 0;
             if (m_k == 19) m_phase = 2;
             else m_k++;
           end else m_stall++;
        default: m_phase = 0;
      endcase
    end
    #1;
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    bus.load_valid = 1'b0;
    bus.rd_req = 1'b0;
    repeat (n) tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_done(input string name);
    bit seen = 0;
    for (int i = 0; i < 400 && !seen; i++) begin
      tick();
      if (obs_load_done) seen = 1;
    end
    chk({name, "_done_seen"}, 32'(seen), 32'd1);
  endtask

  typedef struct {
    logic [1:0] x;
    logic [2:0] y;
    logic       req;
    logic       exp_v;
    logic       exp_p;
  } rd_vec_t;

  rd_vec_t tbl[7];

  initial begin
    logic [19:0] pat;
    int load_cyc, refused, dones, t0, t1;
    bit hold;

    bus.load_valid = 1'b0;
    bus.load_data  = '0;
    bus.rd_req     = 1'b0;
    bus.rd_x       = '0;
    bus.rd_y       = '0;

    tbl[0] = '{2'd3, 3'd4, 1'b1, 1'b1, 1'b1};
    tbl[1] = '{2'd3, 3'd4, 1'b0, 1'b0, 1'b1};
    tbl[2] = '{2'd0, 3'd0, 1'b1, 1'b1, 1'b0};
    tbl[3] = '{2'd2, 3'd4, 1'b1, 1'b1, 1'b0};
    tbl[4] = '{2'd3, 3'd5, 1'b1, 1'b1, 1'b0};
    tbl[5] = '{2'd1, 3'd7, 1'b1, 1'b1, 1'b0};
    tbl[6] = '{2'd3, 3'd3, 1'b1, 1'b1, 1'b0};

    // Plain load timing and read-back.
    do_reset(2);
    tick();
    chk("t1_reset_busy", 32'(obs_busy), 32'd0);
    chk("t1_reset_rd_valid", 32'(obs_rd_valid), 32'd0);
    pat = 20'hF0F0F;
    bus.load_data = pat;
    bus.load_valid = 1'b1;
    tick();
    chk("t1_accept", 32'(obs_load_ready), 32'd1);
    bus.load_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("t1_wr", 32'(obs_mem_write), 32'd1);
      chk("t1_x", 32'(obs_mem_x), 32'(i % 4));
      chk("t1_y", 32'(obs_mem_y), 32'(i / 4));
      chk("t1_din", 32'(obs_din), 32'(pat[i]));
    end
    tick();
    chk("t1_done_n21", 32'(obs_load_done), 32'd1);
    tick();
    chk("t1_ready_n22", 32'(obs_load_ready), 32'd1);
    for (int i = 0; i < 20; i++) begin
      bus.rd_req = 1'b1; bus.rd_x = 2'(i % 4); bus.rd_y = 3'(i / 4);
      tick();
      bus.rd_req = 1'b0;
      tick();
      chk("t1_rb_valid", 32'(obs_rd_valid), 32'd1);
      chk("t1_rb_pixel", 32'(obs_rd_pixel), 32'(pat[i]));
    end

    // Continuous reads: loader progresses only through starvation slots.
    bus.load_data = 20'h00001; bus.load_valid = 1'b1;
    bus.rd_req = 1'b1; bus.rd_x = 2'd2; bus.rd_y = 3'd1;
    tick();
    bus.load_valid = 1'b0;
    load_cyc = 0; refused = 0; dones = 0;
    for (int i = 0; i < 300 && dones == 0; i++) begin
      tick();
      if (obs_load_done) dones++;
      else if (obs_busy) begin
        load_cyc++;
        if (!obs_rd_ready) refused++;
      end
    end
    repeat (5) begin
      tick();
      if (obs_load_done) dones++;
    end
    bus.rd_req = 1'b0;
    chk("t2_load_cycles", 32'(load_cyc), 32'd180);
    chk("t2_forced_slots", 32'(refused), 32'd20);
    chk("t2_done_pulses", 32'(dones), 32'd1);
    tick();

    // Corner reads after a single-pixel glyph.
    bus.load_data = 20'h80000; bus.load_valid = 1'b1;
    tick();
    bus.load_valid = 1'b0;
    wait_done("t3");
    tick();
    for (int i = 0; i < 7; i++) begin
      bus.rd_req = tbl[i].req; bus.rd_x = tbl[i].x; bus.rd_y = tbl[i].y;
      tick();
      bus.rd_req = 1'b0;
      tick();
      chk("t3_tbl_valid", 32'(obs_rd_valid), 32'(tbl[i].exp_v));
      chk("t3_tbl_pixel", 32'(obs_rd_pixel), 32'(tbl[i].exp_p));
    end

    // Reset in the middle of a load.
    bus.load_data = 20'hFFFFF; bus.load_valid = 1'b1;
    tick();
    bus.load_valid = 1'b0;
    repeat (7) tick();
    chk("t4_seventh_write", 32'(obs_mem_write), 32'd1);
    rst_n = 1'b0;
    tick();
    chk("t4_rst_no_write", 32'(obs_mem_write), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("t4_ready", 32'(obs_load_ready), 32'd1);
    chk("t4_busy", 32'(obs_busy), 32'd0);
    chk("t4_no_done", 32'(obs_load_done), 32'd0);
    dones = 0;
    repeat (25) begin
      tick();
      if (obs_load_done) dones++;
    end
    chk("t4_done_pulses", 32'(dones), 32'd0);
    chk("t4_mem_cleared", 32'(dev_mem), 32'd0);

    // Back-to-back glyphs with load_valid held.
    bus.load_data = 20'h12345; bus.load_valid = 1'b1;
    tick();
    chk("t5_accept_a", 32'(obs_load_ready), 32'd1);
    t0 = cyc; t1 = 0; dones = 0;
    bus.load_data = 20'hABCDE;
    for (int i = 0; i < 40 && t1 == 0; i++) begin
      tick();
      if (obs_load_done) dones++;
      if (obs_load_ready) t1 = cyc;
    end
    bus.load_valid = 1'b0;
    chk("t5_b_start", 32'(t1 - t0), 32'd22);
    repeat (30) begin
      tick();
      if (obs_load_done) dones++;
    end
    chk("t5_done_pulses", 32'(dones), 32'd2);
    chk("t5_mem_b", 32'(dev_mem), 32'h000ABCDE);

    // load_valid pulses while busy are ignored.
    bus.load_data = 20'h5A5A5; bus.load_valid = 1'b1;
    tick();
    dones = 0;
    for (int i = 1; i <= 25; i++) begin
      bus.load_valid = (i == 5 || i == 21);
      bus.load_data  = bus.load_valid ? 20'hFFFFF : 20'h5A5A5;
      tick();
      if (bus.load_valid) chk("t6_ignored", 32'(obs_load_ready), 32'd0);
      if (obs_load_done) dones++;
    end
    bus.load_valid = 1'b0;
    repeat (3) tick();
    chk("t6_done_pulses", 32'(dones), 32'd1);
    chk("t6_mem", 32'(dev_mem), 32'h0005A5A5);

    // Random traffic against the reference model.
    hold = 0;
    for (int i = 0; i < 4000; i++) begin
      rst_n = ($urandom_range(0, 599) != 0);
      bus.load_valid = ($urandom_range(0, 9) < 3);
      bus.load_data  = 20'($urandom);
      if (!hold) begin
        bus.rd_req = ($urandom_range(0, 9) < 6);
        bus.rd_x   = 2'($urandom_range(0, 3));
        bus.rd_y   = 3'($urandom_range(0, 7));
      end
      tick();
      hold = bus.rd_req && !obs_rd_ready && rst_n;
    end
    rst_n = 1'b1;
    bus.rd_req = 1'b0;
    bus.load_valid = 1'b0;
    repeat (200) tick();
    chk("rand_mem_final", 32'(dev_mem), 32'(exp_mem));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
